alu_exec_unit: RTL

Multi-cycle RV32I integer execution unit that consumes the 4-bit `ALU_Ctl` code produced by the ALU control decoder and returns a 32-bit result. It sits in the execute stage between the decoder/register-read logic and writeback. Operands and control are accepted with a valid/ready handshake. Shifts are iterative by default, one bit per cycle, and the result is held until writeback accepts it.

---
 rtl/alu_exec_unit.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/alu_exec_unit.sv
// RV32I integer execution unit with a valid/ready handshake on both sides.
// Define ALU_BARREL_SHIFT_EN for single-cycle shifts; the default build shifts one bit per cycle.
module alu_exec_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      ALU_Ctl,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            illegal
);

`ifdef ALU_BARREL_SHIFT_EN
    typedef enum logic [1:0] {IDLE = 2'd0, DONE = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;
`endif

    state_t          state;
    logic [4:0]      shamt;
    logic [XLEN-1:0] imm_res;
    logic            imm_ill;

    assign shamt = op_b[4:0];

`ifndef ALU_BARREL_SHIFT_EN
    logic            is_shift;
    logic [XLEN-1:0] work;
    logic [XLEN-1:0] work_nxt;
    logic [4:0]      cnt;
    logic            sh_left;
    logic            sh_arith;

    always_comb begin
        work_nxt = work;
        if (sh_left)
            work_nxt = {work[XLEN-2:0], 1'b0};
        else
            work_nxt = {sh_arith & work[XLEN-1], work[XLEN-1:1]};
    end
`endif

    // Result of the presented operation; shifts only resolve here in the barrel build
    // or when shamt is 0 (result is op_a unchanged).
    always_comb begin
        imm_res = '0;
        imm_ill = 1'b0;
`ifndef ALU_BARREL_SHIFT_EN
        is_shift = 1'b0;
`endif
        case (ALU_Ctl)
            4'd0: imm_res = op_a + op_b;
            4'd1: imm_res = op_a - op_b;
            4'd2: imm_res = op_a & op_b;
            4'd3: imm_res = op_a | op_b;
            4'd4: imm_res = op_a ^ op_b;
            4'd5: imm_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            4'd6: imm_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
`ifdef ALU_BARREL_SHIFT_EN
            4'd7: imm_res = op_a << shamt;
            4'd8: imm_res = op_a >> shamt;
            4'd9: imm_res = $unsigned($signed(op_a) >>> shamt);
`else
            4'd7, 4'd8, 4'd9: begin
                imm_res  = op_a;
                is_shift = (shamt != 5'd0);
            end
`endif
            default: imm_ill = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b0;
            illegal   <= 1'b0;
`ifndef ALU_BARREL_SHIFT_EN
            cnt       <= 5'd0;
            work      <= '0;
            sh_left   <= 1'b0;
            sh_arith  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        in_ready <= 1'b0;
`ifndef ALU_BARREL_SHIFT_EN
                        if (is_shift) begin
                            state    <= SHIFT;
                            work     <= op_a;
                            cnt      <= shamt;
                            sh_left  <= (ALU_Ctl == 4'd7);
                            sh_arith <= (ALU_Ctl == 4'd9);
                        end else
`endif
                        begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                            result    <= imm_res;
                            zero      <= (imm_res == '0);
                            illegal   <= imm_ill;
                        end
                    end
                end
`ifndef ALU_BARREL_SHIFT_EN
                // The last shift lands straight in result so DONE follows k edges after accept.
                SHIFT: begin
                    work <= work_nxt;
                    cnt  <= cnt - 5'd1;
                    if (cnt == 5'd1) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        result    <= work_nxt;
                        zero      <= (work_nxt == '0);
                        illegal   <= 1'b0;
                    end
                end
`endif
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        in_ready  <= 1'b1;
                        out_valid <= 1'b0;
                        result    <= '0;
                        zero      <= 1'b0;
                        illegal   <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
